// File: rtl/ibex_ex_op_sequencer_pkg.sv
// Shared types for the EX op sequencer: op classes, FSM states, timeout counter width.
package ibex_ex_op_sequencer_pkg;

  typedef enum logic [1:0] {
    EX_ALU   = 2'd0,
    EX_MULT  = 2'd1,
    EX_DIV   = 2'd2,
    EX_CHERI = 2'd3
  } ex_class_e;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_WAIT_MD,
    SEQ_CHERI2,
    SEQ_HOLD
  } ex_seq_state_e;

  localparam int unsigned EX_SEQ_CNT_W = 6;

  typedef logic [EX_SEQ_CNT_W-1:0] md_cnt_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ibex_ex_op_sequencer_if.sv
// Request/result handshake bundle between ID, the EX sequencer and writeback.
interface ibex_ex_op_sequencer_if #(
  parameter int unsigned CAP_W = 93,
  parameter int unsigned EXC_W = 22
);

  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_class;
  logic             req_cheri_2p;
  logic             res_valid;
  logic             res_ready;
  logic [CAP_W-1:0] res_wdata;
  logic [EXC_W-1:0] res_exc;
  logic             res_timeout;

  // ID/writeback side
  modport master (
    output req_valid, req_class, req_cheri_2p, res_ready,
    input  req_ready, res_valid, res_wdata, res_exc, res_timeout
  );

  // sequencer side
  modport slave (
    input  req_valid, req_class, req_cheri_2p, res_ready,
    output req_ready, res_valid, res_wdata, res_exc, res_timeout
  );

endinterface

// File: rtl/ibex_ex_op_sequencer_result_buf.sv
// One-entry hold register for the EX result, exceptions and timeout flag.
module ibex_ex_seq_result_buf #(
  parameter int unsigned CAP_W = 93,
  parameter int unsigned EXC_W = 22
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [CAP_W-1:0] wdata_i,
  input  logic [EXC_W-1:0] exc_i,
  input  logic             timeout_i,
  output logic [CAP_W-1:0] wdata_o,
  output logic [EXC_W-1:0] exc_o,
  output logic             timeout_o
);

  logic [CAP_W-1:0] wdata_q;
  logic [EXC_W-1:0] exc_q;
  logic             timeout_q;

  // load wins so a drain cycle can clear the old entry and capture the next op
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wdata_q   <= '0;
      exc_q     <= '0;
      timeout_q <= 1'b0;
    end else if (load_i) begin
      wdata_q   <= wdata_i;
      exc_q     <= exc_i;
      timeout_q <= timeout_i;
    end else if (clear_i) begin
      wdata_q   <= '0;
      exc_q     <= '0;
      timeout_q <= 1'b0;
    end
  end

  assign wdata_o   = wdata_q;
  assign exc_o     = exc_q;
  assign timeout_o = timeout_q;

endmodule

// File: rtl/ibex_ex_op_sequencer.sv
// EX op sequencer: accepts ops from ID, drives unit enables, holds result toward writeback.
// Optional performance counters enabled by defining IBEX_EX_SEQ_PERF_EN.
module ibex_ex_op_sequencer
  import ibex_ex_op_sequencer_pkg::*;
#(
  parameter int unsigned CAP_W      = 93,
  parameter int unsigned EXC_W      = 22,
  parameter int unsigned MD_TIMEOUT = 40
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  ibex_ex_op_sequencer_if.slave ex_if,
  input  logic                  flush_i,
  output logic                  mult_en_o,
  output logic                  div_en_o,
  output logic                  cheri_en_o,
  output logic                  cheri_pass_o,
  input  logic                  md_valid_i,
  input  logic [CAP_W-1:0]      ex_wdata_i,
  input  logic [EXC_W-1:0]      cheri_exc_i,
  output logic                  busy_o,
  output logic [31:0]           perf_md_cyc_o,
  output logic [31:0]           perf_wb_stall_o
);

  // last WAIT_MD count value before a forced completion (MD_TIMEOUT-1 cycles total)
  localparam md_cnt_t MD_CNT_LAST = md_cnt_t'(MD_TIMEOUT - 2);

  ex_seq_state_e    state_q, state_d;
  logic             md_div_q, md_div_d;
  md_cnt_t          md_cnt_q, md_cnt_d;
  ex_class_e        req_class;
  logic             req_ready;
  logic             accept;
  logic             buf_load, buf_clear, ld_timeout;
  logic [CAP_W-1:0] ld_wdata;
  logic [EXC_W-1:0] ld_exc;

  assign req_class       = ex_class_e'(ex_if.req_class);
  assign req_ready       = !flush_i &&
                           ((state_q == SEQ_IDLE) || ((state_q == SEQ_HOLD) && ex_if.res_ready));
  assign accept          = ex_if.req_valid && req_ready;
  assign ex_if.req_ready = req_ready;
  assign ex_if.res_valid = (state_q == SEQ_HOLD);
  assign busy_o          = (state_q != SEQ_IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= SEQ_IDLE;
      md_div_q <= 1'b0;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_div_q <= md_div_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    md_div_d     = md_div_q;
    md_cnt_d     = md_cnt_q;
    mult_en_o    = 1'b0;
    div_en_o     = 1'b0;
    cheri_en_o   = 1'b0;
    cheri_pass_o = 1'b0;
    buf_load     = 1'b0;
    buf_clear    = 1'b0;
    ld_wdata     = ex_wdata_i;
    ld_exc       = '0;
    ld_timeout   = 1'b0;

    if (flush_i) begin
      state_d   = SEQ_IDLE;
      buf_clear = 1'b1;
    end else begin
      unique case (state_q)
        SEQ_IDLE: ;
        SEQ_WAIT_MD: begin
          mult_en_o = !md_div_q;
          div_en_o  = md_div_q;
          if (md_valid_i) begin
            buf_load = 1'b1;
            state_d  = SEQ_HOLD;
          end else if (md_cnt_q == MD_CNT_LAST) begin
            buf_load   = 1'b1;
            ld_wdata   = '0;
            ld_timeout = 1'b1;
            state_d    = SEQ_HOLD;
          end else begin
            md_cnt_d = md_cnt_q + md_cnt_t'(1'b1);
          end
        end
        SEQ_CHERI2: begin
          cheri_en_o   = 1'b1;
          cheri_pass_o = 1'b1;
          buf_load     = 1'b1;
          ld_exc       = cheri_exc_i;
          state_d      = SEQ_HOLD;
        end
        SEQ_HOLD: begin
          if (ex_if.res_ready) begin
            buf_clear = 1'b1;
            state_d   = SEQ_IDLE;
          end
        end
        default: state_d = SEQ_IDLE;
      endcase

      // a new op overrides the IDLE/HOLD-drain decision above
      if (accept) begin
        unique case (req_class)
          EX_ALU: begin
            buf_load = 1'b1;
            ld_exc   = cheri_exc_i;
            state_d  = SEQ_HOLD;
          end
          EX_MULT, EX_DIV: begin
            mult_en_o = (req_class == EX_MULT);
            div_en_o  = (req_class == EX_DIV);
            md_div_d  = (req_class == EX_DIV);
            md_cnt_d  = '0;
            if (md_valid_i) begin
              buf_load = 1'b1;
              state_d  = SEQ_HOLD;
            end else begin
              state_d  = SEQ_WAIT_MD;
            end
          end
          EX_CHERI: begin
            cheri_en_o = 1'b1;
            if (!ex_if.req_cheri_2p || (cheri_exc_i != '0)) begin
              buf_load = 1'b1;
              ld_exc   = cheri_exc_i;
              state_d  = SEQ_HOLD;
            end else begin
              state_d  = SEQ_CHERI2;
            end
          end
          default: state_d = SEQ_IDLE;
        endcase
      end
    end
  end

  ibex_ex_seq_result_buf #(
    .CAP_W (CAP_W),
    .EXC_W (EXC_W)
  ) u_result_buf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (buf_load),
    .clear_i   (buf_clear),
    .wdata_i   (ld_wdata),
    .exc_i     (ld_exc),
    .timeout_i (ld_timeout),
    .wdata_o   (ex_if.res_wdata),
    .exc_o     (ex_if.res_exc),
    .timeout_o (ex_if.res_timeout)
  );

`ifdef IBEX_EX_SEQ_PERF_EN
  logic [31:0] perf_md_q, perf_stall_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_md_q    <= '0;
      perf_stall_q <= '0;
    end else begin
      if (state_q == SEQ_WAIT_MD) begin
        perf_md_q <= sat_inc32(perf_md_q);
      end
      if ((state_q == SEQ_HOLD) && !ex_if.res_ready) begin
        perf_stall_q <= sat_inc32(perf_stall_q);
      end
    end
  end

  assign perf_md_cyc_o   = perf_md_q;
  assign perf_wb_stall_o = perf_stall_q;
`else
  assign perf_md_cyc_o   = '0;
  assign perf_wb_stall_o = '0;
`endif

endmodule

// File: tb/tb_ibex_ex_op_sequencer.sv
// Bench for ibex_ex_op_sequencer: vector table with a result scoreboard plus hand sequences.
module tb_ibex_ex_op_sequencer;
  import ibex_ex_op_sequencer_pkg::*;

  localparam int CAP_W      = 93;
  localparam int EXC_W      = 22;
  localparam int MD_TIMEOUT = 40;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush, md_valid;
  logic [CAP_W-1:0] ex_wdata;
  logic [EXC_W-1:0] cheri_exc;
  logic             mult_en, div_en, cheri_en, cheri_pass, busy;
  logic [31:0]      perf_md, perf_stall;

  ibex_ex_op_sequencer_if #(.CAP_W(CAP_W), .EXC_W(EXC_W)) ex_if ();

  ibex_ex_op_sequencer #(
    .CAP_W      (CAP_W),
    .EXC_W      (EXC_W),
    .MD_TIMEOUT (MD_TIMEOUT)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .ex_if           (ex_if),
    .flush_i         (flush),
    .mult_en_o       (mult_en),
    .div_en_o        (div_en),
    .cheri_en_o      (cheri_en),
    .cheri_pass_o    (cheri_pass),
    .md_valid_i      (md_valid),
    .ex_wdata_i      (ex_wdata),
    .cheri_exc_i     (cheri_exc),
    .busy_o          (busy),
    .perf_md_cyc_o   (perf_md),
    .perf_wb_stall_o (perf_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       cls;
    logic             two_pass;
    logic [CAP_W-1:0] w0, w1;
    logic [EXC_W-1:0] e0, e1;
    int               md_lat;
    int               exp_lat;
    logic [CAP_W-1:0] exp_w;
    logic [EXC_W-1:0] exp_e;
    logic             exp_to;
  } vec_t;

  typedef struct {
    logic [CAP_W-1:0] w;
    logic [EXC_W-1:0] e;
    logic             to;
  } res_t;

  res_t sb[$];
  vec_t vecs[12];
  int   tests = 0;
  int   fails = 0;
  int   exp_md = 0;
  int   exp_stall = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] perf_exp(input int v);
`ifdef IBEX_EX_SEQ_PERF_EN
    return 32'(v);
`else
    return 32'(v * 0);
`endif
  endfunction

  function automatic vec_t mk(input logic [1:0] cls, input logic tp,
                              input logic [CAP_W-1:0] w0, input logic [CAP_W-1:0] w1,
                              input logic [EXC_W-1:0] e0, input logic [EXC_W-1:0] e1,
                              input int md_lat, input int lat,
                              input logic [CAP_W-1:0] ew, input logic [EXC_W-1:0] ee,
                              input logic eto);
    vec_t v;
    v.cls = cls; v.two_pass = tp; v.w0 = w0; v.w1 = w1; v.e0 = e0; v.e1 = e1;
    v.md_lat = md_lat; v.exp_lat = lat; v.exp_w = ew; v.exp_e = ee; v.exp_to = eto;
    return v;
  endfunction

  function automatic logic [3:0] exp_en(input logic [1:0] cls, input int c);
    case (cls)
      2'd1:    return 4'b1000;
      2'd2:    return 4'b0100;
      2'd3:    return (c == 0) ? 4'b0010 : 4'b0011;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic observe();
    res_t r;
    if (ex_if.res_valid && ex_if.res_ready) begin
      check("sb_pending", 128'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        r = sb.pop_front();
        check("res_wdata", ex_if.res_wdata, r.w);
        check("res_exc", ex_if.res_exc, r.e);
        check("res_timeout", ex_if.res_timeout, r.to);
      end
    end
  endtask

  task automatic idle_inputs();
    ex_if.req_valid = 1'b0;
    md_valid        = 1'b0;
    flush           = 1'b0;
  endtask

  task automatic run_op(input vec_t v);
    logic done;
    done = 1'b0;
    sb.push_back('{w: v.exp_w, e: v.exp_e, to: v.exp_to});
    for (int c = 0; c < 64 && !done; c++) begin
      @(posedge clk); #1;
      ex_if.req_valid    = (c == 0);
      ex_if.req_class    = v.cls;
      ex_if.req_cheri_2p = v.two_pass;
      ex_if.res_ready    = 1'b1;
      ex_wdata           = (c == 0) ? v.w0 : v.w1;
      cheri_exc          = (c == 0) ? v.e0 : v.e1;
      md_valid           = (v.md_lat == c);
      #1;
      if (c == 0) check("req_ready", ex_if.req_ready, 1);
      check("enables", {mult_en, div_en, cheri_en, cheri_pass},
            (c < v.exp_lat) ? exp_en(v.cls, c) : 4'b0000);
      if (c > 0) check("busy_inflight", busy, 1);
      if (ex_if.res_valid) begin
        check("latency", c, v.exp_lat);
        observe();
        done = 1'b1;
      end
    end
    check("result_seen", done, 1);
    @(posedge clk); #1;
    idle_inputs();
    #1;
    check("busy_after", busy, 0);
    check("res_valid_after", ex_if.res_valid, 0);
    if (v.cls == 2'd1 || v.cls == 2'd2) exp_md += v.exp_lat - 1;
    check("perf_md", perf_md, perf_exp(exp_md));
  endtask

  initial begin
    vecs[0]  = mk(2'd0, 0, 93'h5, 93'h9, '0, '0, -1, 1, 93'h5, '0, 0);
    vecs[1]  = mk(2'd0, 0, 93'h1F_DEAD_BEEF_CAFE_F00D_1234, 93'h7, '0, '0, -1, 1,
                  93'h1F_DEAD_BEEF_CAFE_F00D_1234, '0, 0);
    vecs[2]  = mk(2'd1, 0, 93'h100, 93'h200, '0, '0, 3, 4, 93'h200, '0, 0);
    vecs[3]  = mk(2'd1, 0, 93'h300, 93'h400, '0, '0, 0, 1, 93'h300, '0, 0);
    vecs[4]  = mk(2'd2, 0, 93'h500, 93'h600, '0, '0, 7, 8, 93'h600, '0, 0);
    vecs[5]  = mk(2'd1, 0, 93'h700, 93'h7FF, '0, '0, -1, MD_TIMEOUT, '0, '0, 1);
    vecs[6]  = mk(2'd3, 0, 93'h800, 93'h900, 22'h3, 22'h0, -1, 1, 93'h800, 22'h3, 0);
    vecs[7]  = mk(2'd3, 1, 93'hA00, 93'hB00, 22'h0, 22'h6, -1, 2, 93'hB00, 22'h6, 0);
    vecs[8]  = mk(2'd3, 1, 93'hC00, 93'hD00, 22'h4, 22'h0, -1, 1, 93'hC00, 22'h4, 0);
    vecs[9]  = mk(2'd2, 0, 93'hE00, 93'hE01, '0, '0, 1, 2, 93'hE01, '0, 0);
    vecs[10] = mk(2'd3, 1, 93'hF00, 93'hF01, 22'h20_0000, 22'h0, -1, 1, 93'hF00, 22'h20_0000, 0);
    vecs[11] = mk(2'd2, 0, 93'h1234, 93'h5678, '0, '0, MD_TIMEOUT - 1, MD_TIMEOUT, 93'h5678, '0, 0);

    idle_inputs();
    ex_if.req_class    = 2'd0;
    ex_if.req_cheri_2p = 1'b0;
    ex_if.res_ready    = 1'b1;
    ex_wdata           = '0;
    cheri_exc          = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_res_valid", ex_if.res_valid, 0);
    check("rst_req_ready", ex_if.req_ready, 1);
    check("rst_enables", {mult_en, div_en, cheri_en, cheri_pass}, 0);
    check("rst_res_wdata", ex_if.res_wdata, 0);
    check("rst_perf", {perf_md, perf_stall}, 0);

    for (int i = 0; i < 12; i++) run_op(vecs[i]);

    // writeback stall for three cycles, then drain with a back-to-back accept
    @(posedge clk); #1;
    ex_if.req_valid = 1'b1; ex_if.req_class = 2'd0; ex_if.res_ready = 1'b0; ex_wdata = 93'h11;
    #1 check("stall_accept", ex_if.req_ready, 1);
    sb.push_back('{w: 93'h11, e: '0, to: 1'b0});
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      ex_if.req_valid = 1'b0; ex_wdata = 93'h99;
      #1;
      check("stall_valid", ex_if.res_valid, 1);
      check("stall_wdata", ex_if.res_wdata, 93'h11);
      check("stall_ready", ex_if.req_ready, 0);
    end
    @(posedge clk); #1;
    ex_if.res_ready = 1'b1; ex_if.req_valid = 1'b1; ex_wdata = 93'h22;
    #1;
    check("drain_accept", ex_if.req_ready, 1);
    observe();
    sb.push_back('{w: 93'h22, e: '0, to: 1'b0});
    @(posedge clk); #1;
    ex_if.req_valid = 1'b0;
    #1;
    check("no_bubble", ex_if.res_valid, 1);
    observe();
    @(posedge clk); #1;
    check("drain_idle", busy, 0);
    exp_stall += 3;
    check("perf_stall", perf_stall, perf_exp(exp_stall));

    // flush during WAIT_MD cycle 3
    @(posedge clk); #1;
    ex_if.req_valid = 1'b1; ex_if.req_class = 2'd1; md_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      ex_if.req_valid = (c == 3);
      ex_if.req_class = 2'd0;
      flush = (c == 3);
      #1;
      if (c < 3) check("md_mult_en", mult_en, 1);
    end
    check("flush_no_accept", ex_if.req_ready, 0);
    check("flush_enables", {mult_en, div_en, cheri_en, cheri_pass}, 0);
    @(posedge clk); #1;
    idle_inputs();
    #1;
    check("flush_busy", busy, 0);
    check("flush_enables_after", {mult_en, div_en, cheri_en, cheri_pass}, 0);
    check("flush_res_valid", ex_if.res_valid, 0);
    exp_md += 3;
    check("perf_md_flush", perf_md, perf_exp(exp_md));

    // flush while a result is held
    @(posedge clk); #1;
    ex_if.req_valid = 1'b1; ex_if.req_class = 2'd0; ex_if.res_ready = 1'b0; ex_wdata = 93'h77;
    @(posedge clk); #1;
    ex_if.req_valid = 1'b0; flush = 1'b1;
    #1 check("hold_before_flush", ex_if.res_valid, 1);
    @(posedge clk); #1;
    flush = 1'b0; ex_if.res_ready = 1'b1;
    #1;
    check("hold_flush_valid", ex_if.res_valid, 0);
    check("hold_flush_wdata", ex_if.res_wdata, 0);
    exp_stall += 1;
    check("perf_stall_flush", perf_stall, perf_exp(exp_stall));

    // asynchronous reset while in the second CHERI pass
    @(posedge clk); #1;
    ex_if.req_valid = 1'b1; ex_if.req_class = 2'd3; ex_if.req_cheri_2p = 1'b1;
    cheri_exc = '0; ex_wdata = 93'h3C;
    @(posedge clk); #1;
    ex_if.req_valid = 1'b0;
    #1 check("cheri2_pass", {cheri_en, cheri_pass}, 2'b11);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_enables", {mult_en, div_en, cheri_en, cheri_pass}, 0);
    check("rst_mid_res", {ex_if.res_valid, ex_if.res_timeout, ex_if.res_exc}, 0);
    check("rst_mid_wdata", ex_if.res_wdata, 0);
    check("rst_mid_perf", {perf_md, perf_stall}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle", {busy, ex_if.res_valid}, 0);
    check("sb_empty", 128'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
